// File: rtl/alu_pkg.sv
// Shared types and defaults for the serial ALU responder and its chunk datapath.
package alu_pkg;

  localparam int unsigned DefaultWidth = 64;
  localparam int unsigned DefaultChunk = 8;

  typedef enum logic [1:0] {
    OP_NOR = 2'b00,
    OP_XOR = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COMPUTE = 2'b01,
    DONE    = 2'b10
  } alu_state_e;

  // Carry into chunk 0: ADD uses the request carry, SUB needs +1 for two's complement.
  function automatic logic init_carry(input alu_op_e op, input logic cin);
    logic c;
    unique case (op)
      OP_ADD:  c = cin;
      OP_SUB:  c = 1'b1;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

  // Only the arithmetic ops report a carry out.
  function automatic logic op_has_carry(input alu_op_e op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu64bit_serial_resp_if.sv
// Request/response bundle between an operation sequencer (master) and the ALU (slave).
interface alu64bit_serial_resp_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) ();

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             req_cin;
  alu_op_e          req_op;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_s;
  logic             rsp_cout;

  modport master (
    output req_valid, req_a, req_b, req_cin, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_s, rsp_cout
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_s, rsp_cout
  );

endinterface

// File: rtl/alu_chunk.sv
// Combinational CHUNK-bit ALU slice; SUB inverts b here, the caller supplies the +1 as cin.
module alu_chunk
  import alu_pkg::*;
#(
  parameter int unsigned CHUNK = DefaultChunk
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  input  alu_op_e          op,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic [CHUNK-1:0] b_eff;
  logic [CHUNK:0]   sum;

  // Evaluate one slice of the selected operation.
  always_comb begin
    b_eff = (op == OP_SUB) ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {{CHUNK{1'b0}}, cin};
    s     = '0;
    cout  = 1'b0;
    unique case (op)
      OP_NOR:         s = ~(a | b);
      OP_XOR:         s = a ^ b;
      OP_ADD, OP_SUB: {cout, s} = sum;
      default:        s = '0;
    endcase
  end

endmodule

// File: rtl/alu64bit_serial_resp.sv
// Multi-cycle ALU responder: accepts a request, evaluates it CHUNK bits per cycle from the
// LSB with a registered carry between slices, then holds the result until it is taken.
module alu64bit_serial_resp
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned CHUNK = DefaultChunk
) (
  input  logic                   clk,
  input  logic                   rst_n,
  alu64bit_serial_resp_if.slave  bus,
  output logic                   busy
);

  localparam int unsigned NChunk = WIDTH / CHUNK;
  localparam int unsigned CntW   = (NChunk > 1) ? $clog2(NChunk) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NChunk - 1);

  alu_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [NChunk-1:0][CHUNK-1:0] a_q, a_d;
  logic [NChunk-1:0][CHUNK-1:0] b_q, b_d;
  logic [NChunk-1:0][CHUNK-1:0] s_q, s_d;
  alu_op_e op_q, op_d;
  logic    carry_q, carry_d;

  logic [CHUNK-1:0] chunk_s;
  logic             chunk_cout;

  // The single slice datapath sees whichever chunk the counter points at.
  alu_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a    (a_q[cnt_q]),
    .b    (b_q[cnt_q]),
    .cin  (carry_q),
    .op   (op_q),
    .s    (chunk_s),
    .cout (chunk_cout)
  );

  // Next-state: operands only move on an accepted request, so idle-bus X never reaches state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    op_d    = op_q;
    carry_d = carry_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          a_d     = bus.req_a;
          b_d     = bus.req_b;
          op_d    = bus.req_op;
          carry_d = init_carry(bus.req_op, bus.req_cin);
          cnt_d   = '0;
          s_d     = '0;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        s_d[cnt_q] = chunk_s;
        carry_d    = chunk_cout;
        // Hold at the terminal count rather than wrapping.
        if (cnt_q == LastCnt) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      DONE: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      op_q    <= OP_NOR;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      op_q    <= op_d;
      carry_q <= carry_d;
    end
  end

  // Handshake and result outputs decoded from state; results read as zero outside DONE.
  always_comb begin
    bus.req_ready = (state_q == IDLE);
    bus.rsp_valid = (state_q == DONE);
    busy          = (state_q == COMPUTE);
    bus.rsp_s     = (state_q == DONE) ? s_q : '0;
    bus.rsp_cout  = (state_q == DONE) && op_has_carry(op_q) && carry_q;
  end

endmodule
